// File: rtl/biriscv_defs.sv
// Shared definitions for the fetch/decode boundary: slot width and the
// layout of one buffered instruction entry.
package biriscv_defs;

  localparam int FETCH_SLOT_W = 32;
  localparam int ENTRY_W      = 3 + 2 * FETCH_SLOT_W;

  typedef struct packed {
    logic                    fault_page;
    logic                    fault_fetch;
    logic                    pred;
    logic [31:0]             pc;
    logic [FETCH_SLOT_W-1:0] instr;
  } fetch_entry_t;

  function automatic fetch_entry_t make_entry(
    input logic [FETCH_SLOT_W-1:0] instr,
    input logic [31:0]             pc,
    input logic                    pred,
    input logic                    fault_fetch,
    input logic                    fault_page
  );
    fetch_entry_t e;
    e.instr       = instr;
    e.pc          = pc;
    e.pred        = pred;
    e.fault_fetch = fault_fetch;
    e.fault_page  = fault_page;
    return e;
  endfunction

endpackage

// File: rtl/biriscv_fetch_slot_mask.sv
// Decides which slots of a fetch packet are real instructions and lists
// their slot indices in program order.
module biriscv_fetch_slot_mask #(
  parameter  int FETCH_WIDTH   = 2,
  parameter  int FETCH_WIDTH_W = 1,
  localparam int IDX_W         = (FETCH_WIDTH_W > 0) ? FETCH_WIDTH_W : 1,
  localparam int CNT_W         = FETCH_WIDTH_W + 1
) (
  input  logic [31:0]                  pc_i,
  input  logic [FETCH_WIDTH-1:0]       pred_i,
  input  logic                         fault_fetch_i,
  input  logic                         fault_page_i,
  output logic [FETCH_WIDTH-1:0]       slot_valid_o,
  output logic [CNT_W-1:0]             push_cnt_o,
  output logic [FETCH_WIDTH*IDX_W-1:0] slot_idx_o
);

  logic [31:0]      word_addr;
  logic [IDX_W-1:0] first_slot;
  logic [IDX_W-1:0] last_slot;
  logic             found;

  assign word_addr = pc_i >> 2;

  // Valid slots always form one contiguous run [first_slot, last_slot].
  always_comb begin
    first_slot = IDX_W'(word_addr & 32'(FETCH_WIDTH - 1));
    last_slot  = IDX_W'(FETCH_WIDTH - 1);
    found      = 1'b0;
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      if (!found && (IDX_W'(k) >= first_slot) && pred_i[IDX_W'(k)]) begin
        last_slot = IDX_W'(k);
        found     = 1'b1;
      end
    end
    if (fault_fetch_i || fault_page_i) begin
      last_slot = first_slot;
    end
  end

  always_comb begin
    slot_valid_o = '0;
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      slot_valid_o[IDX_W'(k)] = (IDX_W'(k) >= first_slot) && (IDX_W'(k) <= last_slot);
    end
  end

  assign push_cnt_o = CNT_W'(last_slot - first_slot) + CNT_W'(1);

  for (genvar n = 0; n < FETCH_WIDTH; n++) begin : g_idx
    assign slot_idx_o[n*IDX_W +: IDX_W] = first_slot + IDX_W'(n);
  end

endmodule

// File: rtl/biriscv_fetch_queue.sv
// Instruction queue between fetch and decode: one entry per valid slot,
// up to NUM_OUT in-order instructions presented per cycle.
module biriscv_fetch_queue
  import biriscv_defs::*;
#(
  parameter int FETCH_WIDTH   = 2,
  parameter int FETCH_WIDTH_W = 1,
  parameter int NUM_OUT       = 2,
  parameter int DEPTH         = 8,
  parameter int DEPTH_W       = 3
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          fetch_in_valid_i,
  input  logic [32*FETCH_WIDTH-1:0]     fetch_in_instr_i,
  input  logic [31:0]                   fetch_in_pc_i,
  input  logic [FETCH_WIDTH-1:0]        fetch_in_pred_branch_i,
  input  logic                          fetch_in_fault_fetch_i,
  input  logic                          fetch_in_fault_page_i,
  output logic                          fetch_in_accept_o,
  input  logic                          branch_request_i,
  input  logic [NUM_OUT-1:0]            fetch_out_accept_i,
  output logic [NUM_OUT-1:0]            fetch_out_valid_o,
  output logic [32*NUM_OUT-1:0]         fetch_out_instr_o,
  output logic [32*NUM_OUT-1:0]         fetch_out_pc_o,
  output logic [NUM_OUT-1:0]            fetch_out_pred_o,
  output logic [NUM_OUT-1:0]            fetch_out_fault_fetch_o,
  output logic [NUM_OUT-1:0]            fetch_out_fault_page_o,
  output logic [DEPTH_W:0]              level_o
);

  localparam int IDX_W = (FETCH_WIDTH_W > 0) ? FETCH_WIDTH_W : 1;
  localparam int CNT_W = FETCH_WIDTH_W + 1;
  localparam int LVL_W = DEPTH_W + 1;
  localparam int POP_W = $clog2(NUM_OUT + 1);

  fetch_entry_t mem_q [DEPTH];
  fetch_entry_t mem_d [DEPTH];

  logic [DEPTH_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0]   level_q,  level_d;

  logic [FETCH_WIDTH-1:0]       slot_valid;
  logic [CNT_W-1:0]             push_cnt;
  logic [FETCH_WIDTH*IDX_W-1:0] slot_idx;
  logic [IDX_W-1:0]             slot_idx_arr [FETCH_WIDTH];
  logic [FETCH_SLOT_W-1:0]      slot_instr   [FETCH_WIDTH];
  logic [IDX_W-1:0]             sidx;

  logic [31:0]        base_pc;
  logic               pkt_fault;
  logic [LVL_W-1:0]   free_cnt;
  logic               push_en;
  logic [NUM_OUT-1:0] lane_valid;
  logic [NUM_OUT-1:0] pop_hit;
  logic [NUM_OUT-1:0] pop_run;
  logic [POP_W-1:0]   pop_cnt;

  biriscv_fetch_slot_mask #(
    .FETCH_WIDTH   (FETCH_WIDTH),
    .FETCH_WIDTH_W (FETCH_WIDTH_W)
  ) u_slot_mask (
    .pc_i          (fetch_in_pc_i),
    .pred_i        (fetch_in_pred_branch_i),
    .fault_fetch_i (fetch_in_fault_fetch_i),
    .fault_page_i  (fetch_in_fault_page_i),
    .slot_valid_o  (slot_valid),
    .push_cnt_o    (push_cnt),
    .slot_idx_o    (slot_idx)
  );

  for (genvar k = 0; k < FETCH_WIDTH; k++) begin : g_slot
    assign slot_instr[k]   = fetch_in_instr_i[k*FETCH_SLOT_W +: FETCH_SLOT_W];
    assign slot_idx_arr[k] = slot_idx[k*IDX_W +: IDX_W];
  end

  assign base_pc   = fetch_in_pc_i & ~32'(FETCH_WIDTH * 4 - 1);
  assign pkt_fault = fetch_in_fault_fetch_i | fetch_in_fault_page_i;

  // Admission uses the pre-pop level and a full packet's worth of space, so
  // a push can never overrun entries still waiting to be read.
  assign free_cnt          = LVL_W'(DEPTH) - level_q;
  assign fetch_in_accept_o = !rst_i && (branch_request_i || (free_cnt >= LVL_W'(FETCH_WIDTH)));
  assign push_en           = fetch_in_valid_i && fetch_in_accept_o && !branch_request_i;

  always_comb begin
    mem_d = mem_q;
    sidx  = '0;
    for (int n = 0; n < FETCH_WIDTH; n++) begin
      sidx = slot_idx_arr[IDX_W'(n)];
      if (push_en && (CNT_W'(n) < push_cnt) && slot_valid[sidx]) begin
        mem_d[wr_ptr_q + DEPTH_W'(n)] = make_entry(
          pkt_fault ? '0 : slot_instr[sidx],
          base_pc + 32'({sidx, 2'b00}),
          pkt_fault ? 1'b0 : fetch_in_pred_branch_i[sidx],
          fetch_in_fault_fetch_i,
          fetch_in_fault_page_i);
      end
    end
  end

  // Only a run of accepts starting at lane 0 pops; a gap ends the run.
  assign pop_hit    = fetch_out_accept_i & lane_valid;
  assign pop_run[0] = pop_hit[0];
  for (genvar j = 1; j < NUM_OUT; j++) begin : g_run
    assign pop_run[j] = pop_run[j-1] & pop_hit[j];
  end
  assign pop_cnt = POP_W'($countones(pop_run));

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;
    if (branch_request_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_en) begin
        wr_ptr_d = wr_ptr_q + DEPTH_W'(push_cnt);
      end
      rd_ptr_d = rd_ptr_q + DEPTH_W'(pop_cnt);
      level_d  = level_q + (push_en ? LVL_W'(push_cnt) : '0) - LVL_W'(pop_cnt);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q    <= '{default: '0};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
    end
  end

  for (genvar j = 0; j < NUM_OUT; j++) begin : g_lane
    logic [DEPTH_W-1:0] rd_idx;
    assign rd_idx                     = rd_ptr_q + DEPTH_W'(j);
    assign lane_valid[j]              = LVL_W'(j) < level_q;
    assign fetch_out_valid_o[j]       = lane_valid[j];
    assign fetch_out_instr_o[j*32 +: 32] = mem_q[rd_idx].instr;
    assign fetch_out_pc_o[j*32 +: 32]    = mem_q[rd_idx].pc;
    assign fetch_out_pred_o[j]        = mem_q[rd_idx].pred;
    assign fetch_out_fault_fetch_o[j] = mem_q[rd_idx].fault_fetch;
    assign fetch_out_fault_page_o[j]  = mem_q[rd_idx].fault_page;
  end

  assign level_o = level_q;

endmodule

// File: tb/tb_biriscv_fetch_queue.sv
// Self-checking bench for biriscv_fetch_queue: vector table, hand sequences
// for full/flush/reset, and a scoreboard-driven random stream.
module tb_biriscv_fetch_queue;

  localparam int FW    = 2;
  localparam int NO    = 2;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid;
  logic [63:0]   in_instr;
  logic [31:0]   in_pc;
  logic [1:0]    in_pred;
  logic          in_ff;
  logic          in_fp;
  logic          in_accept;
  logic          branch;
  logic [1:0]    out_accept;
  logic [1:0]    out_valid;
  logic [63:0]   out_instr;
  logic [63:0]   out_pc;
  logic [1:0]    out_pred;
  logic [1:0]    out_ff;
  logic [1:0]    out_fp;
  logic [3:0]    level;

  always #5 clk = ~clk;

  biriscv_fetch_queue #(
    .FETCH_WIDTH   (FW),
    .FETCH_WIDTH_W (1),
    .NUM_OUT       (NO),
    .DEPTH         (DEPTH),
    .DEPTH_W       (3)
  ) dut (
    .clk_i                   (clk),
    .rst_i                   (rst),
    .fetch_in_valid_i        (in_valid),
    .fetch_in_instr_i        (in_instr),
    .fetch_in_pc_i           (in_pc),
    .fetch_in_pred_branch_i  (in_pred),
    .fetch_in_fault_fetch_i  (in_ff),
    .fetch_in_fault_page_i   (in_fp),
    .fetch_in_accept_o       (in_accept),
    .branch_request_i        (branch),
    .fetch_out_accept_i      (out_accept),
    .fetch_out_valid_o       (out_valid),
    .fetch_out_instr_o       (out_instr),
    .fetch_out_pc_o          (out_pc),
    .fetch_out_pred_o        (out_pred),
    .fetch_out_fault_fetch_o (out_ff),
    .fetch_out_fault_page_o  (out_fp),
    .level_o                 (level)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        pred;
    logic        ff;
    logic        fp;
  } ent_t;

  typedef struct {
    logic [31:0] pc;
    logic [1:0]  pred;
    logic        ff;
    logic        fp;
    int          cnt;
    logic [31:0] l0_instr;
    logic [31:0] l0_pc;
    logic        l0_pred;
    logic        l0_ff;
    logic        l0_fp;
    logic [31:0] l1_instr;
    logic [31:0] l1_pc;
    logic        l1_pred;
  } vec_t;

  ent_t sb[$];
  vec_t vecs[8];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic ent_t lane(input int j);
    ent_t e;
    e.instr = (j == 0) ? out_instr[31:0] : out_instr[63:32];
    e.pc    = (j == 0) ? out_pc[31:0]    : out_pc[63:32];
    e.pred  = (j == 0) ? out_pred[0]     : out_pred[1];
    e.ff    = (j == 0) ? out_ff[0]       : out_ff[1];
    e.fp    = (j == 0) ? out_fp[0]       : out_fp[1];
    return e;
  endfunction

  task automatic chk_lane(input string tag, input int j, input ent_t e);
    ent_t a;
    a = lane(j);
    chk({tag, "_valid"}, (j == 0) ? out_valid[0] : out_valid[1], 1'b1);
    chk({tag, "_instr"}, a.instr, e.instr);
    chk({tag, "_pc"},    a.pc,    e.pc);
    chk({tag, "_pred"},  a.pred,  e.pred);
    chk({tag, "_ff"},    a.ff,    e.ff);
    chk({tag, "_fp"},    a.fp,    e.fp);
  endtask

  // Reference model of one accepted packet: contiguous slots from the PC
  // slot up to the first predicted-taken one; a fault keeps only the first.
  function automatic void model_push(input logic [31:0] pc, input logic [1:0] pred,
                                     input logic ff, input logic fp, input logic [63:0] ins);
    int   first;
    int   last;
    logic found;
    ent_t e;
    first = pc[2] ? 1 : 0;
    last  = 1;
    found = 1'b0;
    if (ff || fp) last = first;
    else begin
      for (int k = first; k < 2; k++) begin
        if (!found && ((k == 0) ? pred[0] : pred[1])) begin
          last  = k;
          found = 1'b1;
        end
      end
    end
    for (int k = first; k <= last; k++) begin
      e.instr = (ff || fp) ? 32'h0 : ((k == 0) ? ins[31:0] : ins[63:32]);
      e.pc    = {pc[31:3], 3'b000} + 32'(4 * k);
      e.pred  = (ff || fp) ? 1'b0 : ((k == 0) ? pred[0] : pred[1]);
      e.ff    = ff;
      e.fp    = fp;
      sb.push_back(e);
    end
  endfunction

  task automatic drive_pkt(input logic [31:0] pc, input logic [1:0] pred,
                           input logic ff, input logic fp, input logic [63:0] ins);
    in_valid = 1'b1;
    in_pc    = pc;
    in_pred  = pred;
    in_ff    = ff;
    in_fp    = fp;
    in_instr = ins;
  endtask

  task automatic idle();
    in_valid   = 1'b0;
    in_pred    = 2'b00;
    in_ff      = 1'b0;
    in_fp      = 1'b0;
    branch     = 1'b0;
    out_accept = 2'b00;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    out_accept = 2'b11;
    while (level != 0 && n < 12) begin
      tick();
      n++;
    end
    out_accept = 2'b00;
    chk({tag, "_drained"}, level, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    ent_t e;
    int   cyc;
    int   accepted;
    int   pkt;
    int   npop;
    logic exp_acc;

    vecs[0] = '{32'h1000, 2'b00, 1'b0, 1'b0, 2, 32'h1111_0000, 32'h1000, 1'b0, 1'b0, 1'b0, 32'h2222_0000, 32'h1004, 1'b0};
    vecs[1] = '{32'h1004, 2'b00, 1'b0, 1'b0, 1, 32'h2222_0001, 32'h1004, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0};
    vecs[2] = '{32'h2000, 2'b10, 1'b0, 1'b0, 2, 32'h1111_0002, 32'h2000, 1'b0, 1'b0, 1'b0, 32'h2222_0002, 32'h2004, 1'b1};
    vecs[3] = '{32'h3000, 2'b01, 1'b0, 1'b0, 1, 32'h1111_0003, 32'h3000, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0};
    vecs[4] = '{32'h4004, 2'b01, 1'b0, 1'b0, 1, 32'h2222_0004, 32'h4004, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0};
    vecs[5] = '{32'h5000, 2'b00, 1'b1, 1'b0, 1, 32'h0,         32'h5000, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0};
    vecs[6] = '{32'h6004, 2'b11, 1'b0, 1'b1, 1, 32'h0,         32'h6004, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0};
    vecs[7] = '{32'h7008, 2'b11, 1'b0, 1'b0, 1, 32'h1111_0007, 32'h7008, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0};

    idle();
    in_pc    = '0;
    in_instr = '0;
    #2;
    chk("reset_accept", in_accept, 1'b0);
    chk("reset_level",  level,     0);
    chk("reset_valid",  out_valid, 2'b00);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("post_reset_accept", in_accept, 1'b1);

    // Single-packet vectors, each into an empty queue.
    for (int i = 0; i < 8; i++) begin
      drive_pkt(vecs[i].pc, vecs[i].pred, vecs[i].ff, vecs[i].fp,
                {32'h2222_0000 + 32'(i), 32'h1111_0000 + 32'(i)});
      tick();
      idle();
      chk($sformatf("vec%0d_level", i), level, 64'(vecs[i].cnt));
      e = '{vecs[i].l0_instr, vecs[i].l0_pc, vecs[i].l0_pred, vecs[i].l0_ff, vecs[i].l0_fp};
      chk_lane($sformatf("vec%0d_l0", i), 0, e);
      if (vecs[i].cnt == 2) begin
        e = '{vecs[i].l1_instr, vecs[i].l1_pc, vecs[i].l1_pred, 1'b0, 1'b0};
        chk_lane($sformatf("vec%0d_l1", i), 1, e);
      end else begin
        chk($sformatf("vec%0d_l1_valid", i), out_valid[1], 1'b0);
      end
      out_accept = 2'b11;
      tick();
      out_accept = 2'b00;
      chk($sformatf("vec%0d_pop_level", i), level, 0);
    end

    // Back-to-back predicted packets.
    drive_pkt(32'h2000, 2'b10, 1'b0, 1'b0, {32'hB1, 32'hB0});
    tick();
    drive_pkt(32'h3000, 2'b01, 1'b0, 1'b0, {32'hC1, 32'hC0});
    tick();
    idle();
    chk("pred_seq_level", level, 3);
    chk_lane("pred_seq_l0", 0, '{32'hB0, 32'h2000, 1'b0, 1'b0, 1'b0});
    chk_lane("pred_seq_l1", 1, '{32'hB1, 32'h2004, 1'b1, 1'b0, 1'b0});
    out_accept = 2'b11;
    tick();
    out_accept = 2'b00;
    chk("pred_seq_level2", level, 1);
    chk_lane("pred_seq_l0b", 0, '{32'hC0, 32'h3000, 1'b1, 1'b0, 1'b0});
    chk("pred_seq_l1b_valid", out_valid[1], 1'b0);
    drain("pred_seq");

    // Fill to 7, full back-pressure, gapped accept ignored.
    for (int i = 0; i < 3; i++) begin
      drive_pkt(32'hA000 + 32'(8 * i), 2'b00, 1'b0, 1'b0, {32'hA1, 32'hA0});
      tick();
    end
    chk("fill6_level", level, 6);
    chk("fill6_accept", in_accept, 1'b1);
    drive_pkt(32'hA01C, 2'b00, 1'b0, 1'b0, {32'hA3, 32'hA2});
    tick();
    chk("full_level", level, 7);
    chk("full_accept", in_accept, 1'b0);
    drive_pkt(32'hA020, 2'b00, 1'b0, 1'b0, {32'hA5, 32'hA4});
    tick();
    idle();
    chk("full_hold_level", level, 7);
    out_accept = 2'b10;
    tick();
    chk("gap_accept_level", level, 7);
    out_accept = 2'b11;
    tick();
    out_accept = 2'b00;
    chk("pop2_level", level, 5);
    chk("pop2_accept", in_accept, 1'b1);
    drain("full");

    // Random stream against the scoreboard, crossing the pointer wrap.
    sb.delete();
    cyc = 0;
    accepted = 0;
    pkt = 0;
    while ((accepted < 20 || sb.size() != 0) && cyc < 600) begin
      if (accepted < 20 && $urandom_range(0, 3) != 0) begin
        drive_pkt(32'h8000_0000 + 32'(pkt * 8) + (($urandom_range(0, 1) == 1) ? 32'h4 : 32'h0),
                  ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                  {32'($urandom), 32'($urandom)});
      end else begin
        in_valid = 1'b0;
      end
      out_accept = (accepted >= 20) ? 2'b11 : 2'($urandom_range(0, 3));
      #1;
      exp_acc = (DEPTH - sb.size()) >= FW;
      chk("rnd_accept", in_accept, exp_acc);
      chk("rnd_level", level, 64'(sb.size()));
      for (int j = 0; j < 2; j++) begin
        if (j < sb.size()) chk_lane($sformatf("rnd_l%0d", j), j, sb[j]);
        else chk($sformatf("rnd_l%0d_valid", j), (j == 0) ? out_valid[0] : out_valid[1], 1'b0);
      end
      npop = 0;
      if (out_accept[0] && sb.size() > 0) begin
        npop = 1;
        if (out_accept[1] && sb.size() > 1) npop = 2;
      end
      repeat (npop) void'(sb.pop_front());
      if (in_valid && exp_acc) begin
        model_push(in_pc, in_pred, in_ff, in_fp, in_instr);
        accepted++;
        pkt++;
      end
      tick();
      cyc++;
    end
    idle();
    chk("rnd_packets", accepted, 20);
    chk("rnd_empty", level, 0);

    // Flush with a packet presented in the same cycle.
    for (int i = 0; i < 3; i++) begin
      drive_pkt(32'hD000 + 32'(8 * i), 2'b00, 1'b0, 1'b0, {32'hD1, 32'hD0});
      tick();
    end
    idle();
    chk("flush_pre_level", level, 6);
    drive_pkt(32'hB000, 2'b00, 1'b0, 1'b0, {32'hE1, 32'hE0});
    branch     = 1'b1;
    out_accept = 2'b11;
    #1;
    chk("flush_accept", in_accept, 1'b1);
    tick();
    idle();
    chk("flush_level", level, 0);
    chk("flush_valid", out_valid, 2'b00);
    tick();
    chk("flush_level2", level, 0);
    chk("flush_valid2", out_valid, 2'b00);
    drive_pkt(32'hC004, 2'b00, 1'b0, 1'b0, {32'hF1, 32'hF0});
    tick();
    idle();
    chk("post_flush_level", level, 1);
    chk_lane("post_flush_l0", 0, '{32'hF1, 32'hC004, 1'b0, 1'b0, 1'b0});

    // Asynchronous reset between clock edges.
    drive_pkt(32'hC008, 2'b00, 1'b0, 1'b0, {32'hF3, 32'hF2});
    tick();
    idle();
    chk("pre_rst_level", level, 3);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid",  out_valid, 2'b00);
    chk("async_rst_level",  level,     0);
    chk("async_rst_accept", in_accept, 1'b0);
    #2 rst = 1'b0;
    tick();
    chk("after_rst_level",  level,     0);
    chk("after_rst_accept", in_accept, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
